hex_to_pixel_mapper: RTL and testbench

HEX_TO_PIXEL_MAPPER -- requirements
Module: hex_to_pixel_mapper

---
 rtl/hex_pkg.sv | 28 ++
 rtl/hex_pipe_reg.sv | 29 ++
 rtl/hex_to_pixel_mapper.sv | 124 ++++++++++++
 tb/tb_hex_to_pixel_mapper.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hex_pkg.sv
// Shared hex-grid constants and pipeline stage bundles.
// Also used by the rasterizer, so constants live here rather than locally.
package hex_pkg;

   localparam int COORD_W        = 32;
   localparam int FRAC_BITS      = 16;
   localparam int SQRT3_HALF_Q16 = 56756;
   localparam int TERM_W         = COORD_W + 2;
   localparam int PROD_W         = 64;

   typedef struct packed {
      logic [COORD_W-1:0]       size;
      logic signed [TERM_W-1:0] q3;
      logic signed [TERM_W-1:0] t;
   } s1_t;

   typedef struct packed {
      logic signed [PROD_W-1:0] xp;
      logic signed [PROD_W-1:0] yp;
   } s2_t;

   typedef struct packed {
      logic signed [COORD_W-1:0] x;
      logic signed [COORD_W-1:0] y;
      logic                      clip;
   } s3_t;

endpackage

// File: rtl/hex_pipe_reg.sv
// One valid/data pipeline stage; loads whenever empty or draining.
// Data is held while stalled so downstream sees stable values.
module hex_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         up_valid,
   input  logic [W-1:0] up_data,
   input  logic         down_ready,
   output logic         valid,
   output logic [W-1:0] data,
   output logic         ready
);

   assign ready = !valid || down_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (ready) begin
         valid <= up_valid;
         if (up_valid)
            data <= up_data;
      end
   end

endmodule

// File: rtl/hex_to_pixel_mapper.sv
// Axial hex coordinate to pixel centre, 3-stage valid/ready pipeline.
// S1: 3q and 2r+q, S2: scale by size, S3: Q16 sqrt(3)/2, shifts, clip.
module hex_to_pixel_mapper
   import hex_pkg::*;
#(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [COORD_W-1:0] hex_q,
   input  logic signed [COORD_W-1:0] hex_r,
   input  logic [COORD_W-1:0]        hex_size,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [COORD_W-1:0] pix_x,
   output logic signed [COORD_W-1:0] pix_y,
   output logic                      clip,
   output logic [15:0]               out_count
);

   localparam logic signed [PROD_W-1:0] K = PROD_W'(SQRT3_HALF_Q16);

   s1_t  s1_d, s1_q;
   s2_t  s2_d, s2_q;
   s3_t  s3_d, s3_q;
   logic v1, v2, v3;
   logic rdy1, rdy2, rdy3;
   logic run;

   logic signed [TERM_W-1:0] qe, re;
   logic signed [PROD_W-1:0] sz, q3w, tw;
   logic signed [PROD_W-1:0] xp, yk;
   logic signed [COORD_W-1:0] px, py;

   // Holds in_ready low through reset and until the first edge after it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         run <= 1'b0;
      else
         run <= 1'b1;
   end

   assign in_ready = run && rdy1;

   always_comb begin
      qe = {{2{hex_q[COORD_W-1]}}, hex_q};
      re = {{2{hex_r[COORD_W-1]}}, hex_r};
      s1_d      = '0;
      s1_d.size = hex_size;
      s1_d.q3   = qe + (qe <<< 1);
      s1_d.t    = (re <<< 1) + qe;
   end

   always_comb begin
      sz  = {{(PROD_W-COORD_W){1'b0}}, s1_q.size};
      q3w = {{(PROD_W-TERM_W){s1_q.q3[TERM_W-1]}}, s1_q.q3};
      tw  = {{(PROD_W-TERM_W){s1_q.t[TERM_W-1]}}, s1_q.t};
      s2_d    = '0;
      s2_d.xp = sz * q3w;
      s2_d.yp = sz * tw;
   end

   // Arithmetic shifts floor toward -inf; clip uses signed compares.
   always_comb begin
      xp = s2_q.xp;
      yk = s2_q.yp * K;
      px = COORD_W'(xp >>> 1);
      py = COORD_W'(yk >>> FRAC_BITS);
      s3_d      = '0;
      s3_d.x    = px;
      s3_d.y    = py;
      s3_d.clip = (px < 0) || (px >= SCREEN_W) ||
                  (py < 0) || (py >= SCREEN_H);
   end

   hex_pipe_reg #(.W($bits(s1_t))) u_s1 (
      .clk        (clk),
      .reset      (reset),
      .up_valid   (in_valid && run),
      .up_data    (s1_d),
      .down_ready (rdy2),
      .valid      (v1),
      .data       (s1_q),
      .ready      (rdy1)
   );

   hex_pipe_reg #(.W($bits(s2_t))) u_s2 (
      .clk        (clk),
      .reset      (reset),
      .up_valid   (v1),
      .up_data    (s2_d),
      .down_ready (rdy3),
      .valid      (v2),
      .data       (s2_q),
      .ready      (rdy2)
   );

   hex_pipe_reg #(.W($bits(s3_t))) u_s3 (
      .clk        (clk),
      .reset      (reset),
      .up_valid   (v2),
      .up_data    (s3_d),
      .down_ready (out_ready),
      .valid      (v3),
      .data       (s3_q),
      .ready      (rdy3)
   );

   assign out_valid = v3;
   assign pix_x     = s3_q.x;
   assign pix_y     = s3_q.y;
   assign clip      = s3_q.clip;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         out_count <= '0;
      else if (out_valid && out_ready)
         out_count <= out_count + 16'd1;
   end

endmodule

// File: tb/tb_hex_to_pixel_mapper.sv
// Directed bench for hex_to_pixel_mapper with hand-computed vectors.
// Inputs change and outputs are sampled around the falling edge.
module tb_hex_to_pixel_mapper;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic               out_ready = 1'b1;
   logic signed [31:0] hex_q = '0;
   logic signed [31:0] hex_r = '0;
   logic [31:0]        hex_size = '0;
   logic               in_ready, out_valid, clip;
   logic signed [31:0] pix_x, pix_y;
   logic [15:0]        out_count;

   int errors = 0;
   int checks = 0;
   int n_out  = 0;

   // q, r, size -> x, y, clip
   int vq[8] = '{1, 2, -1, 5, 4, 0, 3, 10};
   int vr[8] = '{0, 1, 0, 0, -1, 6, 2, 5};
   int vs[8] = '{2, 10, 10, 100, 20, 100, 0, 40};
   int ex[8] = '{3, 30, -15, 750, 120, 0, 0, 600};
   int ey[8] = '{1, 34, -9, 433, 34, 1039, 0, 692};
   int ec[8] = '{0, 0, 1, 1, 0, 1, 0, 1};

   hex_to_pixel_mapper #(.SCREEN_W(640), .SCREEN_H(480)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .hex_q     (hex_q),
      .hex_r     (hex_r),
      .hex_size  (hex_size),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .clip      (clip),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag,
                  $signed(got), $signed(exp));
      end
   endtask

   task automatic send_one(input int q, input int r, input int s,
                           input int x, input int y, input int c);
      hex_q = q; hex_r = r; hex_size = s;
      in_valid = 1'b1; out_ready = 1'b1;
      #1 check("accept_rdy", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      hex_size = $urandom;
      check("lat1", out_valid, 0);
      @(negedge clk);
      check("lat2", out_valid, 0);
      @(negedge clk);
      check("lat3", out_valid, 1);
      check("one_x", pix_x, x);
      check("one_y", pix_y, y);
      check("one_clip", clip, c);
      @(negedge clk);
      n_out++;
      check("one_cnt", out_count, 64'(16'(n_out)));
      check("one_drain", out_valid, 0);
   endtask

   task automatic run_stream(input int stall);
      int  sent = 0;
      int  got = 0;
      int  cyc = 0;
      int  stalled = 0;
      bit  acc, con;
      while (got < 8 && cyc < 200) begin
         out_ready = !(got == 1 && stalled < stall);
         in_valid = (sent < 8);
         if (sent < 8) begin
            hex_q = vq[sent]; hex_r = vr[sent]; hex_size = vs[sent];
         end else begin
            hex_size = $urandom;
         end
         #1;
         if (!out_ready) begin
            stalled++;
            check("hold_valid", out_valid, 1);
            check("hold_x", pix_x, ex[1]);
            check("hold_y", pix_y, ey[1]);
            if (stalled == stall) begin
               check("stall_rdy", in_ready, 0);
               check("stall_sent", sent, 4);
            end
         end
         acc = in_valid && in_ready;
         con = out_valid && out_ready;
         if (con) begin
            check("str_x", pix_x, ex[got]);
            check("str_y", pix_y, ey[got]);
            check("str_clip", clip, ec[got]);
            got++;
            n_out++;
         end
         @(negedge clk);
         if (acc) sent++;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("str_all", got, 8);
      check("str_cycles", cyc, 11 + stall);
      check("str_cnt", out_count, 64'(16'(n_out)));
   endtask

   initial begin
      bit stale;
      repeat (2) @(negedge clk);
      check("rst_rdy", in_ready, 0);
      check("rst_ov", out_valid, 0);
      check("rst_x", pix_x, 0);
      check("rst_cnt", out_count, 0);
      reset = 1'b0;
      #1 check("rel_rdy0", in_ready, 0);
      @(negedge clk);
      check("rel_rdy1", in_ready, 1);

      send_one(2, 1, 10, 30, 34, 0);
      send_one(-1, 0, 10, -15, -9, 1);
      send_one(5, 0, 100, 750, 433, 1);
      send_one(7, -3, 0, 0, 0, 0);
      send_one(-1, 1, 1, -2, 0, 1);
      send_one(426, -213, 1, 639, 0, 0);
      send_one(427, -213, 1, 640, 0, 1);
      send_one(0, 6, 100, 0, 1039, 1);

      run_stream(0);
      run_stream(6);

      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         hex_q = vq[i]; hex_r = vr[i]; hex_size = vs[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("pre_rst_ov", out_valid, 1);
      #2 reset = 1'b1;
      #1;
      check("ar_ov", out_valid, 0);
      check("ar_rdy", in_ready, 0);
      check("ar_x", pix_x, 0);
      check("ar_y", pix_y, 0);
      check("ar_clip", clip, 0);
      check("ar_cnt", out_count, 0);
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      n_out = 0;
      stale = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      check("no_stale", stale, 0);
      check("post_cnt", out_count, 0);
      send_one(2, 1, 10, 30, 34, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
